// File: rtl/regbank_axil_arbiter_if.sv
// AXI4-Lite bus between the request arbiter (master) and the register bank (slave).
interface regbank_axil_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/regbank_axil_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite register-bank port among NUM_REQ requesters,
// one outstanding transaction at a time.
//   state   | meaning
//   IDLE    | waiting for any req_valid; grant decided here
//   WR      | AW and W channels presented, each dropped on its own handshake
//   WR_RESP | both write handshakes done, waiting for B
//   RD_ADDR | AR presented
//   RD_DATA | waiting for R
module regbank_axil_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_wstrb,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  regbank_axil_arbiter_if.master        m_axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [STRB_W-1:0]  wstrb_q;
  logic               awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand;
  logic               win_we;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;
  logic [STRB_W-1:0]  win_wstrb;
  logic [PTR_W-1:0]   ptr_next;

  // Search upward from rr_ptr with wrap; cand is one bit wider so the sum cannot overflow.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_wstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == win_idx) begin
        win_we    = req_we[i];
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[i*DATA_W +: DATA_W];
        win_wstrb = req_wstrb[i*STRB_W +: STRB_W];
      end
    end
    win_addr[1:0] = 2'b00;
  end

  assign ptr_next = (grant == PTR_W'(NUM_REQ-1)) ? '0 : grant + PTR_W'(1);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (win_found) begin
            grant              <= win_idx;
            addr_q             <= win_addr;
            wdata_q            <= win_wdata;
            wstrb_q            <= win_wstrb;
            req_ready[win_idx] <= 1'b1;
            if (win_we) begin
              state     <= WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              bready_q  <= 1'b1;
            end else begin
              state     <= RD_ADDR;
              arvalid_q <= 1'b1;
              rready_q  <= 1'b1;
            end
          end
        end
        WR: begin
          if (m_axi.M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (m_axi.M_AXI_WREADY)  wvalid_q  <= 1'b0;
          // An early B (accepted while still in WR) completes the write directly.
          if (m_axi.M_AXI_BVALID) begin
            awvalid_q        <= 1'b0;
            wvalid_q         <= 1'b0;
            bready_q         <= 1'b0;
            rsp_valid[grant] <= 1'b1;
            rsp_rdata        <= '0;
            rsp_err          <= m_axi.M_AXI_BRESP[1];
            rr_ptr           <= ptr_next;
            state            <= IDLE;
          end else if ((!awvalid_q || m_axi.M_AXI_AWREADY) &&
                       (!wvalid_q  || m_axi.M_AXI_WREADY)) begin
            state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi.M_AXI_BVALID) begin
            bready_q         <= 1'b0;
            rsp_valid[grant] <= 1'b1;
            rsp_rdata        <= '0;
            rsp_err          <= m_axi.M_AXI_BRESP[1];
            rr_ptr           <= ptr_next;
            state            <= IDLE;
          end
        end
        RD_ADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi.M_AXI_RVALID) begin
            rready_q         <= 1'b0;
            rsp_valid[grant] <= 1'b1;
            rsp_rdata        <= m_axi.M_AXI_RDATA;
            rsp_err          <= m_axi.M_AXI_RRESP[1];
            rr_ptr           <= ptr_next;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = wstrb_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;

  // Only RESP[1] (SLVERR/DECERR) is reported upward.
  logic unused_resp;
  assign unused_resp = m_axi.M_AXI_BRESP[0] ^ m_axi.M_AXI_RRESP[0];
endmodule

// File: tb/tb_regbank_axil_arbiter.sv
// Directed bench for regbank_axil_arbiter with a small behavioural register-bank slave.
module tb_regbank_axil_arbiter;
  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_we = '0;
  logic [7:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;
  logic [1:0] pend = '0;

  regbank_axil_arbiter_if #(.ADDR_W(4), .DATA_W(32)) axi ();

  regbank_axil_arbiter #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi(axi)
  );

  always #5 ACLK = ~ACLK;

  // Slave: READYs combinational, B/R one cycle after the address/data are captured.
  int          aw_stall_cfg = 0;
  logic        b_block = 1'b0;
  logic        r_force = 1'b0;
  logic [31:0] r_force_data = '0;
  int          aw_wait;
  logic        aw_got, w_got, ar_got, s_bvalid, s_rvalid;
  logic [3:0]  aw_a, ar_a, w_s;
  logic [31:0] w_d, s_rdata;
  logic [1:0]  s_rresp;
  logic [31:0] mem [4];

  assign axi.M_AXI_AWREADY = (aw_wait >= aw_stall_cfg);
  assign axi.M_AXI_WREADY  = 1'b1;
  assign axi.M_AXI_ARREADY = 1'b1;
  assign axi.M_AXI_BRESP   = 2'b00;
  assign axi.M_AXI_BVALID  = s_bvalid;
  assign axi.M_AXI_RDATA   = s_rdata;
  assign axi.M_AXI_RRESP   = s_rresp;
  assign axi.M_AXI_RVALID  = s_rvalid;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0;
      aw_a <= '0; ar_a <= '0; w_d <= '0; w_s <= '0;
    end else begin
      if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
        aw_got <= 1'b1; aw_a <= axi.M_AXI_AWADDR; aw_wait <= 0;
      end else if (axi.M_AXI_AWVALID) begin
        aw_wait <= aw_wait + 1;
      end
      if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
        w_got <= 1'b1; w_d <= axi.M_AXI_WDATA; w_s <= axi.M_AXI_WSTRB;
      end
      if (aw_got && w_got && !s_bvalid && !b_block) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) mem[aw_a[3:2]][8*b +: 8] <= w_d[8*b +: 8];
        aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b1;
      end
      if (s_bvalid && axi.M_AXI_BREADY) s_bvalid <= 1'b0;
      if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
        ar_got <= 1'b1; ar_a <= axi.M_AXI_ARADDR;
      end
      if (ar_got && !s_rvalid) begin
        ar_got   <= 1'b0;
        s_rvalid <= 1'b1;
        s_rdata  <= r_force ? r_force_data : mem[ar_a[3:2]];
        s_rresp  <= r_force ? 2'b10 : 2'b00;
      end
      if (s_rvalid && axi.M_AXI_RREADY) s_rvalid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Requester contract: a pending request must not be withdrawn before req_ready.
  task automatic tick();
    chk("req_hold", 32'(pend & ~req_valid & ~req_ready), 32'd0);
    pend = req_valid & ~req_ready;
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_req(input int idx, input logic we, input logic [3:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic err, output logic [3:0] awa, output logic [31:0] wdo,
                        output logic [3:0] ara, output logic [2:0] vld);
    logic got_rdy, got_rsp;
    got_rdy = 1'b0; got_rsp = 1'b0;
    lat = 0; rd = '0; err = 1'b0; awa = '0; wdo = '0; ara = '0; vld = '0;
    req_we[idx] = we;
    req_addr[idx*4 +: 4] = addr;
    req_wdata[idx*32 +: 32] = wd;
    req_wstrb[idx*4 +: 4] = 4'hF;
    req_valid[idx] = 1'b1;
    while (!got_rsp && lat < 40) begin
      tick();
      lat++;
      if (!got_rdy && req_ready[idx]) begin
        got_rdy = 1'b1;
        req_valid[idx] = 1'b0;
        awa = axi.M_AXI_AWADDR; wdo = axi.M_AXI_WDATA; ara = axi.M_AXI_ARADDR;
        vld = {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID};
      end
      if (rsp_valid[idx]) begin
        got_rsp = 1'b1; rd = rsp_rdata; err = rsp_err;
      end
    end
    chk("rsp_seen", 32'(got_rsp), 32'd1);
  endtask

  task automatic load_b2b(input int i, input int j);
    req_we[i] = 1'b1;
    req_addr[i*4 +: 4] = 4'(4*j);
    req_wdata[i*32 +: 32] = (i == 0) ? 32'(j+1) : 32'(j+5);
    req_wstrb[i*4 +: 4] = 4'hF;
  endtask

  int lat, cyc, ng, nrsp, n_aw, n_w, n_b, n_rsp;
  int n [2];
  int order [8];
  logic [31:0] rd, wdo;
  logic err, got;
  logic [3:0] awa, ara;
  logic [2:0] vld;
  logic [1:0] seen;

  initial begin
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_axi_valid_ready", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY,
                                    axi.M_AXI_ARVALID, axi.M_AXI_RREADY}), 32'd0);
    chk("rst_axi_addr_data", 32'({axi.M_AXI_AWADDR, axi.M_AXI_ARADDR, axi.M_AXI_WSTRB}), 32'd0);
    chk("rst_wdata", axi.M_AXI_WDATA, 32'd0);

    // Basic write then read-back by the other requester
    do_req(0, 1'b1, 4'h4, 32'hDEADBEEF, lat, rd, err, awa, wdo, ara, vld);
    chk("wr_latency", 32'(lat), 32'd4);
    chk("wr_awaddr", 32'(awa), 32'h4);
    chk("wr_wdata", wdo, 32'hDEADBEEF);
    chk("wr_valids", 32'(vld), 32'b110);
    chk("wr_err", 32'(err), 32'd0);
    chk("wr_rdata_zero", rd, 32'd0);
    do_req(1, 1'b0, 4'h4, 32'd0, lat, rd, err, awa, wdo, ara, vld);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_valids", 32'(vld), 32'b001);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(err), 32'd0);

    // Both requesters stream 4 writes each; grants must alternate 0,1,0,1...
    n[0] = 0; n[1] = 0; ng = 0; nrsp = 0; cyc = 0;
    load_b2b(0, 0); load_b2b(1, 0);
    req_valid = 2'b11;
    while ((ng < 8 || nrsp < 8) && cyc < 200) begin
      tick();
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i]) begin
          if (ng < 8) order[ng] = i;
          ng++;
          n[i]++;
          if (n[i] < 4) load_b2b(i, n[i]);
          else req_valid[i] = 1'b0;
        end
        if (rsp_valid[i]) nrsp++;
      end
    end
    chk("b2b_grants", 32'(ng), 32'd8);
    chk("b2b_rsps", 32'(nrsp), 32'd8);
    for (int k = 0; k < 8; k++) chk("rr_order", 32'(order[k]), 32'(k % 2));
    for (int k = 0; k < 4; k++) begin
      do_req(0, 1'b0, 4'(4*k), 32'd0, lat, rd, err, awa, wdo, ara, vld);
      chk("b2b_readback", rd, 32'(k+5));
    end

    // AWREADY held low 3 cycles, WREADY immediate
    aw_stall_cfg = 3;
    req_we[1] = 1'b1; req_addr[7:4] = 4'h8; req_wdata[63:32] = 32'hA5A5A5A5;
    req_wstrb[7:4] = 4'hF; req_valid[1] = 1'b1;
    n_aw = 0; n_w = 0; n_b = 0; n_rsp = 0; cyc = 0;
    while (cyc < 30) begin
      tick();
      cyc++;
      if (req_ready[1]) req_valid[1] = 1'b0;
      if (axi.M_AXI_AWVALID) n_aw++;
      if (axi.M_AXI_WVALID) n_w++;
      if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) n_b++;
      if (rsp_valid != 2'b00) n_rsp++;
    end
    aw_stall_cfg = 0;
    chk("stall_awvalid_cycles", 32'(n_aw), 32'd4);
    chk("stall_wvalid_cycles", 32'(n_w), 32'd1);
    chk("stall_b_handshakes", 32'(n_b), 32'd1);
    chk("stall_rsp_count", 32'(n_rsp), 32'd1);

    // Error response on read
    r_force = 1'b1; r_force_data = 32'h12345678;
    do_req(1, 1'b0, 4'h0, 32'd0, lat, rd, err, awa, wdo, ara, vld);
    r_force = 1'b0;
    chk("rresp_err", 32'(err), 32'd1);
    chk("rresp_rdata", rd, 32'h12345678);

    // Unaligned address is word-aligned on the bus
    do_req(0, 1'b0, 4'h7, 32'd0, lat, rd, err, awa, wdo, ara, vld);
    chk("align_araddr", 32'(ara), 32'h4);
    chk("align_rdata", rd, 32'd6);

    // Reset while waiting for B
    b_block = 1'b1;
    req_we[1] = 1'b1; req_addr[7:4] = 4'hC; req_wdata[63:32] = 32'h77;
    req_valid[1] = 1'b1;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if (req_ready[1]) begin got = 1'b1; req_valid[1] = 1'b0; end
    end
    chk("rst_test_grant", 32'(got), 32'd1);
    repeat (3) tick();
    chk("pre_rst_bready", 32'(axi.M_AXI_BREADY), 32'd1);
    chk("pre_rst_awvalid", 32'(axi.M_AXI_AWVALID), 32'd0);
    chk("pre_rst_ptr", 32'(dut.rr_ptr), 32'd1);
    ARESET = 1'b1;
    tick();
    chk("mid_rst_valids", 32'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID,
                               axi.M_AXI_BREADY, axi.M_AXI_RREADY}), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_ptr", 32'(dut.rr_ptr), 32'd0);
    ARESET = 1'b0;
    b_block = 1'b0;
    seen = '0;
    repeat (6) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("no_rsp_after_rst", 32'(seen), 32'd0);
    do_req(1, 1'b0, 4'h4, 32'd0, lat, rd, err, awa, wdo, ara, vld);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_rdata", rd, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
